// File: rtl/gestor_vidas.sv
// rtl/gestor_vidas.sv - match controller: lives counters, round sequencing, serve requests
//
// Purpose: owns the left/right lives counters shown in the HUD and sequences each round.
//   The round order is IDLE -> PLAY -> PAUSE (after a goal) -> PLAY, until a side runs out of lives.
//   It then enters OVER. Ball motion is gated through freeze, and serve pulses relaunch the ball.
// Ports:
//   clk        in   system/pixel clock
//   rst_n      in   asynchronous reset, active low
//   frame_tick in   one-cycle pulse per video frame
//   start      in   start button level (rising edge acts)
//   goal_l     in   ball past left edge level (left concedes)
//   goal_r     in   ball past right edge level (right concedes)
//   vidasi     out  left lives
//   vidasd     out  right lives
//   freeze     out  1 = physics halted
//   serve      out  one-cycle serve pulse
//   serve_dir  out  serve direction, 0 = toward left, 1 = toward right
//   game_over  out  1 while in OVER
//   winner     out  01 left won, 10 right won, 11 draw, 00 none
module gestor_vidas #(
  parameter int MAX_LIVES    = 7,
  parameter int LIVES_W      = 3,
  parameter int PAUSE_FRAMES = 60,
  parameter int PAUSE_W      = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               goal_l,
  input  logic               goal_r,
  output logic [LIVES_W-1:0] vidasi,
  output logic [LIVES_W-1:0] vidasd,
  output logic               freeze,
  output logic               serve,
  output logic               serve_dir,
  output logic               game_over,
  output logic [1:0]         winner
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_OVER} state_t;

  localparam logic [LIVES_W-1:0] L_MAX   = LIVES_W'(MAX_LIVES);
  localparam logic [LIVES_W-1:0] L_ONE   = LIVES_W'(1);
  localparam logic [LIVES_W-1:0] L_ZERO  = '0;
  localparam logic [PAUSE_W-1:0] P_LAST  = PAUSE_W'(PAUSE_FRAMES - 1);
  localparam logic [PAUSE_W-1:0] P_ONE   = PAUSE_W'(1);

  state_t             r_state;
  logic [LIVES_W-1:0] r_vi, r_vd;
  logic               r_freeze, r_serve, r_dir, r_go;
  logic [1:0]         r_win;
  logic [PAUSE_W-1:0] r_cnt;

  // Input sync stage (_s) followed by a previous-value stage (_q) for edge detection.
  logic r_start_s, r_start_q, r_gl_s, r_gl_q, r_gr_s, r_gr_q;

  state_t             w_state_n;
  logic [LIVES_W-1:0] w_vi_n, w_vd_n;
  logic               w_freeze_n, w_serve_n, w_dir_n, w_go_n;
  logic [1:0]         w_win_n;
  logic [PAUSE_W-1:0] w_cnt_n;
  logic               w_start_ev, w_gl_ev, w_gr_ev;

  assign w_start_ev = r_start_s & ~r_start_q;
  assign w_gl_ev    = r_gl_s & ~r_gl_q;
  assign w_gr_ev    = r_gr_s & ~r_gr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_vi      <= L_MAX;
      r_vd      <= L_MAX;
      r_freeze  <= 1'b1;
      r_serve   <= 1'b0;
      r_dir     <= 1'b0;
      r_go      <= 1'b0;
      r_win     <= 2'b00;
      r_cnt     <= '0;
      r_start_s <= 1'b0;
      r_start_q <= 1'b0;
      r_gl_s    <= 1'b0;
      r_gl_q    <= 1'b0;
      r_gr_s    <= 1'b0;
      r_gr_q    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_vi      <= w_vi_n;
      r_vd      <= w_vd_n;
      r_freeze  <= w_freeze_n;
      r_serve   <= w_serve_n;
      r_dir     <= w_dir_n;
      r_go      <= w_go_n;
      r_win     <= w_win_n;
      r_cnt     <= w_cnt_n;
      r_start_s <= start;
      r_start_q <= r_start_s;
      r_gl_s    <= goal_l;
      r_gl_q    <= r_gl_s;
      r_gr_s    <= goal_r;
      r_gr_q    <= r_gr_s;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_vi_n     = r_vi;
    w_vd_n     = r_vd;
    w_freeze_n = 1'b1;
    w_serve_n  = 1'b0;
    w_dir_n    = r_dir;
    w_go_n     = r_go;
    w_win_n    = r_win;
    w_cnt_n    = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_ev) begin
          w_serve_n  = 1'b1;
          w_dir_n    = 1'b1;
          w_freeze_n = 1'b0;
          w_state_n  = S_PLAY;
        end
      end
      S_PLAY: begin
        w_freeze_n = 1'b0;
        if (w_gl_ev || w_gr_ev) begin
          // Saturate at zero so a counter can never wrap to a value the HUD misreads.
          if (w_gl_ev && r_vi != L_ZERO) w_vi_n = r_vi - L_ONE;
          if (w_gr_ev && r_vd != L_ZERO) w_vd_n = r_vd - L_ONE;
          w_freeze_n = 1'b1;
          // Serve goes toward the side that conceded; a double goal serves right.
          w_dir_n    = w_gr_ev;
          w_cnt_n    = '0;
          if (w_vi_n == L_ZERO || w_vd_n == L_ZERO) begin
            w_go_n    = 1'b1;
            w_win_n   = {w_vi_n == L_ZERO, w_vd_n == L_ZERO};
            w_state_n = S_OVER;
          end else begin
            w_state_n = S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        if (frame_tick) begin
          if (r_cnt == P_LAST) begin
            w_serve_n  = 1'b1;
            w_freeze_n = 1'b0;
            w_cnt_n    = '0;
            w_state_n  = S_PLAY;
          end else begin
            w_cnt_n = r_cnt + P_ONE;
          end
        end
      end
      S_OVER: begin
        if (w_start_ev) begin
          w_vi_n    = L_MAX;
          w_vd_n    = L_MAX;
          w_win_n   = 2'b00;
          w_go_n    = 1'b0;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign vidasi    = r_vi;
  assign vidasd    = r_vd;
  assign freeze    = r_freeze;
  assign serve     = r_serve;
  assign serve_dir = r_dir;
  assign game_over = r_go;
  assign winner    = r_win;

endmodule

// File: tb/tb_gestor_vidas.sv
// tb/tb_gestor_vidas.sv - scoreboard bench for gestor_vidas with a game-rules reference model
module tb_gestor_vidas;

  localparam int MAXL = 7;
  localparam int PF   = 60;
  localparam int PH_IDLE = 0, PH_PLAY = 1, PH_PAUSE = 2, PH_OVER = 3;

  logic clk = 1'b0;
  logic rst_n, frame_tick, start, goal_l, goal_r;
  logic [2:0] vidasi, vidasd;
  logic freeze, serve, serve_dir, game_over;
  logic [1:0] winner;

  always #5 clk = ~clk;

  gestor_vidas dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .goal_l(goal_l), .goal_r(goal_r), .vidasi(vidasi), .vidasd(vidasd),
    .freeze(freeze), .serve(serve), .serve_dir(serve_dir),
    .game_over(game_over), .winner(winner)
  );

  int n_checks = 0;
  int n_fails  = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_last, mon_prev;
  bit mon_en = 1'b0;

  // Reference model state: game rules in plain integers.
  int m_phase, m_vi, m_vd, m_cnt, m_dir;

  function automatic logic [11:0] snap(int vi, int vd, int fr, int sv, int dir, int go, int win);
    return {3'(vi), 3'(vd), 1'(fr), 1'(sv), 1'(dir), 1'(go), 2'(win)};
  endfunction

  function automatic logic [11:0] dut_snap();
    return {vidasi, vidasd, freeze, serve, serve_dir, game_over, winner};
  endfunction

  task automatic push(logic [11:0] s);
    if (s != exp_last) begin
      exp_q.push_back(s);
      exp_last = s;
    end
  endtask

  // Monitor: every change of the output bundle must match the next expected snapshot.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [11:0] cur;
      cur = dut_snap();
      if (cur !== mon_prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL unexpected_output t=%0t got=%03h required=no change from %03h", $time, cur, mon_prev);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fails++;
            $display("FAIL output_bundle t=%0t got=%03h required=%03h", $time, cur, e);
          end
        end
        mon_prev = cur;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_start(int hold);
    if (m_phase == PH_IDLE) begin
      m_dir = 1;
      push(snap(m_vi, m_vd, 0, 1, 1, 0, 0));
      push(snap(m_vi, m_vd, 0, 0, 1, 0, 0));
      m_phase = PH_PLAY;
    end else if (m_phase == PH_OVER) begin
      m_vi = MAXL;
      m_vd = MAXL;
      push(snap(m_vi, m_vd, 1, 0, m_dir, 0, 0));
      m_phase = PH_IDLE;
    end
    start = 1'b1;
    cyc(hold);
    start = 1'b0;
    cyc(4);
  endtask

  task automatic goal(int l, int r, int hold);
    if (m_phase == PH_PLAY) begin
      if (l != 0 && m_vi > 0) m_vi--;
      if (r != 0 && m_vd > 0) m_vd--;
      m_dir = (r != 0) ? 1 : 0;
      m_cnt = 0;
      if (m_vi == 0 || m_vd == 0) begin
        int w;
        w = (m_vi == 0 && m_vd == 0) ? 3 : ((m_vd == 0) ? 1 : 2);
        push(snap(m_vi, m_vd, 1, 0, m_dir, 1, w));
        m_phase = PH_OVER;
      end else begin
        push(snap(m_vi, m_vd, 1, 0, m_dir, 0, 0));
        m_phase = PH_PAUSE;
      end
    end
    goal_l = l[0];
    goal_r = r[0];
    cyc(hold);
    goal_l = 1'b0;
    goal_r = 1'b0;
    cyc(4);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      if (m_phase == PH_PAUSE) begin
        m_cnt++;
        if (m_cnt == PF) begin
          push(snap(m_vi, m_vd, 0, 1, m_dir, 0, 0));
          push(snap(m_vi, m_vd, 0, 0, m_dir, 0, 0));
          m_phase = PH_PLAY;
        end
      end
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc($urandom_range(0, 2));
    end
    cyc(3);
  endtask

  task automatic do_reset();
    push(snap(MAXL, MAXL, 1, 0, 0, 0, 0));
    m_phase = PH_IDLE; m_vi = MAXL; m_vd = MAXL; m_cnt = 0; m_dir = 0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; goal_l = 1'b0; goal_r = 1'b0;
    m_phase = PH_IDLE; m_vi = MAXL; m_vd = MAXL; m_cnt = 0; m_dir = 0;
    cyc(3);
    n_checks++;
    if (dut_snap() !== snap(MAXL, MAXL, 1, 0, 0, 0, 0)) begin
      n_fails++;
      $display("FAIL reset_state got=%03h required=%03h", dut_snap(), snap(MAXL, MAXL, 1, 0, 0, 0, 0));
    end
    exp_last = snap(MAXL, MAXL, 1, 0, 0, 0, 0);
    mon_prev = exp_last;
    mon_en   = 1'b1;
    rst_n    = 1'b1;
    cyc(3);

    // First serve, then a held goal counted once and a full pause.
    press_start(2);
    goal(1, 0, 5);
    ticks(PF);

    // Goals during pause and start edges in play/pause are ignored.
    goal(0, 1, 2);
    ticks(20);
    goal(1, 0, 3);
    press_start(1);
    ticks(40);
    press_start(3);

    // Run the right side down to zero, then restart.
    while (m_phase != PH_OVER) begin
      goal(0, 1, $urandom_range(1, 4));
      if (m_phase == PH_PAUSE) ticks(PF);
    end
    press_start(2);

    // Both at one life, then a simultaneous double goal -> draw.
    press_start(1);
    for (int i = 0; i < 6; i++) begin
      goal(1, 0, 1);
      ticks(PF);
      goal(0, 1, 1);
      ticks(PF);
    end
    goal(1, 1, 2);
    press_start(1);

    // Reset in the middle of a pause.
    press_start(1);
    goal(1, 0, 2);
    ticks(30);
    do_reset();

    // Randomized play.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 6))
        0:       press_start($urandom_range(1, 4));
        1, 2:    goal(1, 0, $urandom_range(1, 5));
        3, 4:    goal(0, 1, $urandom_range(1, 5));
        5:       goal(1, 1, $urandom_range(1, 3));
        default: ticks($urandom_range(0, 70));
      endcase
    end

    cyc(10);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL missing_outputs got=%0d pending required=0 pending", exp_q.size());
    end
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
